ram_port_arbiter: RTL and testbench

//  Shares the single 10-bit command port of the SPI-side RAM between two requesters.

---
 rtl/ram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of the RAM 10-bit command port.
// Optional read watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter #(
    parameter int ADDR_SIZE   = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic                 we_0,
    input  logic                 we_1,
    input  logic [ADDR_SIZE-1:0] addr_0,
    input  logic [ADDR_SIZE-1:0] addr_1,
    input  logic [7:0]           wdata_0,
    input  logic [7:0]           wdata_1,
    output logic                 ack_0,
    output logic                 ack_1,
    output logic [7:0]           rdata_0,
    output logic [7:0]           rdata_1,
    output logic                 err_0,
    output logic                 err_1,
    output logic                 busy,
    output logic                 gnt_id,
    output logic                 ram_rx_valid,
    output logic [9:0]           ram_din,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_RD,
        DONE
    } state_t;

    state_t     state;
    logic       ptr;
    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;

    logic       pick;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

`ifdef RAM_ARB_TIMEOUT_EN
    logic [15:0] cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

    // Winner among current requesters; pointer breaks ties
    always_comb begin
        pick      = (req_0 & req_1) ? ptr : req_1;
        sel_we    = pick ? we_1 : we_0;
        sel_addr  = pick ? 8'(addr_1) : 8'(addr_0);
        sel_wdata = pick ? wdata_1 : wdata_0;
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            ack_0        <= 1'b0;
            ack_1        <= 1'b0;
            rdata_0      <= 8'h00;
            rdata_1      <= 8'h00;
            err_0        <= 1'b0;
            err_1        <= 1'b0;
            busy         <= 1'b0;
            gnt_id       <= 1'b0;
            ram_rx_valid <= 1'b0;
            ram_din      <= 10'h000;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt          <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_0 | req_1) begin
                        state        <= ADDR;
                        busy         <= 1'b1;
                        gnt_id       <= pick;
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        ram_rx_valid <= 1'b1;
                        ram_din      <= {sel_we ? 2'b00 : 2'b10, sel_addr};
                    end
                end
                ADDR: begin
                    state   <= DATA;
                    ram_din <= we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
                end
                DATA: begin
                    ram_rx_valid <= 1'b0;
                    ram_din      <= 10'h000;
`ifdef RAM_ARB_TIMEOUT_EN
                    cnt          <= 16'd0;
`endif
                    if (we_q) begin
                        state <= DONE;
                        if (gnt_id) ack_1 <= 1'b1;
                        else        ack_0 <= 1'b1;
                    end else begin
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        state <= DONE;
                        if (gnt_id) begin
                            ack_1   <= 1'b1;
                            rdata_1 <= ram_dout;
                        end else begin
                            ack_0   <= 1'b1;
                            rdata_0 <= ram_dout;
                        end
`ifdef RAM_ARB_TIMEOUT_EN
                    end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
                        state <= DONE;
                        if (gnt_id) begin
                            ack_1   <= 1'b1;
                            err_1   <= 1'b1;
                            rdata_1 <= 8'hFF;
                        end else begin
                            ack_0   <= 1'b1;
                            err_0   <= 1'b1;
                            rdata_0 <= 8'hFF;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
`endif
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ack_0  <= 1'b0;
                    ack_1  <= 1'b0;
                    err_0  <= 1'b0;
                    err_1  <= 1'b0;
                    ptr    <= ~gnt_id;
                    gnt_id <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of the two-port RAM arbiter.
// Define RAM_ARB_TIMEOUT_EN to also exercise the read watchdog.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_0, req_1, we_0, we_1;
    logic [7:0] addr_0, addr_1, wdata_0, wdata_1;
    logic       ack_0, ack_1, err_0, err_1;
    logic [7:0] rdata_0, rdata_1;
    logic       busy, gnt_id, ram_rx_valid;
    logic [9:0] ram_din;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .ADDR_SIZE(8),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_0(req_0),
        .req_1(req_1),
        .we_0(we_0),
        .we_1(we_1),
        .addr_0(addr_0),
        .addr_1(addr_1),
        .wdata_0(wdata_0),
        .wdata_1(wdata_1),
        .ack_0(ack_0),
        .ack_1(ack_1),
        .rdata_0(rdata_0),
        .rdata_1(rdata_1),
        .err_0(err_0),
        .err_1(err_1),
        .busy(busy),
        .gnt_id(gnt_id),
        .ram_rx_valid(ram_rx_valid),
        .ram_din(ram_din),
        .ram_dout(ram_dout),
        .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
        addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
        ram_dout = 0; ram_tx_valid = 0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_rxv", ram_rx_valid, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_ack", {ack_1, ack_0}, 0);
        chk("rst_rdata", {rdata_1, rdata_0}, 0);
        chk("rst_err", {err_1, err_0}, 0);
        rst = 0;
        tick;

        // write A5 to 3C from requester 0
        req_0 = 1; we_0 = 1; addr_0 = 8'h3C; wdata_0 = 8'hA5;
        tick;
        chk("wr_c1_din", ram_din, 10'h03C);
        chk("wr_c1_rxv", ram_rx_valid, 1);
        chk("wr_c1_busy", busy, 1);
        chk("wr_c1_gnt", gnt_id, 0);
        tick;
        chk("wr_c2_din", ram_din, 10'h1A5);
        chk("wr_c2_ack", ack_0, 0);
        tick;
        chk("wr_c3_ack", {ack_1, ack_0}, 2'b01);
        chk("wr_c3_rxv", ram_rx_valid, 0);
        chk("wr_c3_din", ram_din, 0);
        chk("wr_c3_err", err_0, 0);
        req_0 = 0;
        tick;
        chk("wr_c4_ack", ack_0, 0);
        chk("wr_c4_busy", busy, 0);

        // read-back from requester 1 with stale tx_valid beforehand
        req_1 = 1; we_1 = 0; addr_1 = 8'h3C;
        ram_tx_valid = 1; ram_dout = 8'h77;
        tick;
        chk("rd_c1_din", ram_din, 10'h23C);
        chk("rd_c1_gnt", gnt_id, 1);
        ram_tx_valid = 0;
        tick;
        chk("rd_c2_din", ram_din, 10'h300);
        chk("rd_c2_rxv", ram_rx_valid, 1);
        tick;
        chk("rd_c3_ack", ack_1, 0);
        chk("rd_c3_busy", busy, 1);
        chk("rd_c3_rxv", ram_rx_valid, 0);
        tick;
        chk("rd_wait_ack", ack_1, 0);
        ram_tx_valid = 1; ram_dout = 8'hA5;
        tick;
        chk("rd_ack", {ack_1, ack_0}, 2'b10);
        chk("rd_rdata", rdata_1, 8'hA5);
        chk("rd_err", err_1, 0);
        req_1 = 0; ram_tx_valid = 0; ram_dout = 8'h00;
        tick;
        chk("rd_ack_off", ack_1, 0);
        chk("rd_hold", rdata_1, 8'hA5);

        // contention from reset: expect 0, 1, 0
        rst = 1;
        tick;
        rst = 0;
        req_0 = 1; we_0 = 1; addr_0 = 8'h01; wdata_0 = 8'h10;
        req_1 = 1; we_1 = 1; addr_1 = 8'h02; wdata_1 = 8'h21;
        for (int k = 0; k < 3; k++) begin
            logic exp_id;
            exp_id = 1'(k % 2);
            tick;
            chk("ct_gnt", gnt_id, exp_id);
            chk("ct_adr", ram_din, exp_id ? 10'h002 : 10'h001);
            tick;
            chk("ct_dat", ram_din, exp_id ? 10'h121 : 10'h110);
            tick;
            chk("ct_ack", {ack_1, ack_0}, exp_id ? 2'b10 : 2'b01);
            if (exp_id) req_1 = 0;
            else        req_0 = 0;
            if (k == 2) req_1 = 0;
            tick;
            chk("ct_idle", busy, 0);
            if (k < 2) begin
                if (exp_id) req_1 = 1;
                else        req_0 = 1;
            end
        end

        // reset during a read
        req_0 = 1; we_0 = 0; addr_0 = 8'h55;
        tick;
        chk("rr_c1_gnt", gnt_id, 0);
        tick;
        chk("rr_c2_din", ram_din, 10'h300);
        rst = 1;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_rxv", ram_rx_valid, 0);
        chk("rr_din", ram_din, 0);
        req_0 = 0;
        tick;
        rst = 0;
        ram_tx_valid = 1; ram_dout = 8'hEE;
        tick; tick;
        chk("rr_noack", {ack_1, ack_0}, 0);
        chk("rr_rdata", rdata_0, 0);
        ram_tx_valid = 0;
        req_0 = 1; we_0 = 1; addr_0 = 8'h0A; wdata_0 = 8'h0B;
        req_1 = 1; we_1 = 1;
        tick;
        chk("rr_regnt", gnt_id, 0);
        tick; tick;
        chk("rr_ack", {ack_1, ack_0}, 2'b01);
        req_0 = 0; req_1 = 0;
        tick;

        // back-to-back on requester 0
        req_0 = 1; we_0 = 1; addr_0 = 8'h0F; wdata_0 = 8'h5A;
        tick; tick; tick;
        chk("bb_ack1", ack_0, 1);
        tick;
        chk("bb_gap_rxv", ram_rx_valid, 0);
        chk("bb_gap_ack", ack_0, 0);
        tick;
        chk("bb_rxv", ram_rx_valid, 1);
        chk("bb_gnt", gnt_id, 0);
        chk("bb_din", ram_din, 10'h00F);
        req_0 = 0;
        tick; tick;
        chk("bb_ack2", ack_0, 1);
        tick;

`ifdef RAM_ARB_TIMEOUT_EN
        // read with no RAM response times out after 4 cycles
        req_1 = 1; we_1 = 0; addr_1 = 8'h20;
        for (int i = 1; i <= 6; i++) begin
            tick;
            chk("to_noack", ack_1, 0);
        end
        tick;
        chk("to_ack", ack_1, 1);
        chk("to_err", err_1, 1);
        chk("to_rdata", rdata_1, 8'hFF);
        req_1 = 0;
        tick;
        chk("to_err_off", err_1, 0);
`else
        // without the watchdog a silent RAM keeps the read pending
        req_1 = 1; we_1 = 0; addr_1 = 8'h20;
        for (int i = 1; i <= 10; i++) begin
            tick;
            chk("nt_noack", ack_1, 0);
        end
        chk("nt_busy", busy, 1);
        req_1 = 0;
        ram_tx_valid = 1; ram_dout = 8'h3E;
        tick;
        chk("nt_ack", ack_1, 1);
        chk("nt_err", err_1, 0);
        chk("nt_rdata", rdata_1, 8'h3E);
        ram_tx_valid = 0;
        tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
